register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- General-purpose register file for the 16-bit CPU datapath: 8 registers × 16 bits.
- Two independent combinational read ports (Operand0, Operand1) feed the ALU operand inputs.
- One write port takes the ALU result and writes it into every register whose enable bit is set, on the rising clock edge.

Parameters:
- DATA_W, 16, register and port data width
- NUM_REGS, 8, number of registers; must equal 2**SEL_W
- SEL_W, 3, width of read-select inputs

Ports:
- clk  input  1  system clock; all writes on rising edge
- reset  input  1  asynchronous, active-low reset; clears all registers
- ALUresult  input  DATA_W  write data
- en  input  NUM_REGS  per-register write enable; bit i targets register Ri
- sel0  input  SEL_W  read-port-0 register select
- sel1  input  SEL_W  read-port-1 register select
- Operand0  output  DATA_W  contents of register[sel0]
- Operand1  output  DATA_W  contents of register[sel1]

Behaviour:
- Storage: R0..R7, DATA_W bits each.
- Reset, asynchronous:
  - Low reset immediately forces R0..R7 to 0, independent of clk.
  - Registers hold 0 while reset is low; writes are ignored.
  - Operand0 and Operand1 therefore read 0 during reset.
- Reset release: deassertion (high) takes effect for the next rising clk edge. No synchronizer inside; the caller handles reset-release timing.
- Write, on rising clk with reset high:
  - For every i with en[i]=1, Ri <= ALUresult.
  - Registers with en[i]=0 hold.
- Multiple enable bits may be set; all selected registers load the same value in the same edge. en=all-ones broadcasts to all 8.
- en=0: no register changes.
- en bits that are X/Z are treated as undefined; the bench drives only 0/1.
- Read:
  - Purely combinational, zero latency.
  - Operand0 = R[sel0], Operand1 = R[sel1].
  - A select change updates the output in the same delta, with no clock needed.
- sel0 == sel1 is legal; both outputs show the same register.
- Read during write, without OPT feature: the read port shows the old value until the clock edge, and the new value immediately after it. One-edge write-to-read latency.
- Undefined data/select: no special handling needed. Outputs are X only if inputs are X. Before first reset, register contents are undefined.
- No other state, no handshakes, no FSM.

Optional Feature:
- Macro: REGBANK_READ_BYPASS_EN.
- Defined:
  - Each read port gets a combinational write-through bypass. If en[sel_k]=1 and reset is high, Operand_k = ALUresult in the same cycle, before the clock edge.
  - Otherwise it reads the stored register.
  - The clock-edge update of storage is unchanged.
  - During reset low, bypass is disabled and outputs read 0.
- Not defined: outputs always show stored contents only (baseline behaviour above).

Test Plan:
- Reset:
  - Stimulus: pulse reset low mid-cycle (no clk edge) after writing 0x1234 to all registers.
  - Response: Operand0/Operand1 become 0x0000 immediately for every sel0/sel1 pair 0..7.
- Broadcast write and read latency:
  - Stimulus: reset high, en=8'hFF, ALUresult=16'h0001, one rising edge.
  - Response: all 8 registers read 0x0001 on both ports.
  - Before the edge (no bypass), reads return the prior value.
- Write disabled:
  - Stimulus: en=8'h00, ALUresult=16'h00F0, several edges.
  - Response: all registers keep their previous value (e.g. 0x0008).
  - Stimulus: then en=8'hFF, ALUresult=16'h0CF0, one edge.
  - Response: sel0=6, sel1=7 read 0x0CF0.
- Selective write:
  - Stimulus: after clearing, en=8'b0000_0100, ALUresult=16'hABCD, one edge.
  - Response: R2=0xABCD; R0, R1 and R3..R7 remain 0.
- Read ports:
  - Stimulus: write distinct values Ri=i*0x1111 via one-hot en. Sweep sel0/sel1 over all 64 combinations without clocking.
  - Response: outputs match immediately, including sel0==sel1.
- Bypass, REGBANK_READ_BYPASS_EN defined:
  - Stimulus: en=8'b0000_1000, ALUresult=16'h5A5A, sel0=3, before edge.
  - Response: Operand0=0x5A5A combinationally.
  - Without the macro: Operand0 shows the old R3 until the edge.

Source files
------------

// File: rtl/register_bank_if.sv
// -----------------------------------------------------------------------------
// register_bank_if
// Bus bundle between the CPU datapath and the general-purpose register file.
//
// Signals:
//   ALUresult  write data presented to the register file
//   en         per-register write enable, bit i targets register Ri
//   sel0/sel1  read-port register selects
//   Operand0/1 read-port data returned by the register file
//
// Modports:
//   master  datapath side: drives write data, enables and selects
//   slave   register-file side: drives the two operand outputs
// -----------------------------------------------------------------------------
interface register_bank_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
);
  logic [DATA_W-1:0]   ALUresult;
  logic [NUM_REGS-1:0] en;
  logic [SEL_W-1:0]    sel0;
  logic [SEL_W-1:0]    sel1;
  logic [DATA_W-1:0]   Operand0;
  logic [DATA_W-1:0]   Operand1;

  modport master (
    output ALUresult,
    output en,
    output sel0,
    output sel1,
    input  Operand0,
    input  Operand1
  );

  modport slave (
    input  ALUresult,
    input  en,
    input  sel0,
    input  sel1,
    output Operand0,
    output Operand1
  );
endinterface : register_bank_if

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// General-purpose register file for the 16-bit CPU datapath: NUM_REGS
// registers of DATA_W bits, one multi-target write port and two independent
// combinational read ports feeding the ALU operands.
//
// Ports:
//   clk    system clock, writes happen on the rising edge
//   reset  asynchronous active-low reset, clears every register
//   bus    register_bank_if.slave
//            ALUresult  write data
//            en         per-register write enable (several bits may be set)
//            sel0/sel1  read selects
//            Operand0/1 register[sel0] / register[sel1]
//
// Build option:
//   REGBANK_READ_BYPASS_EN  when defined, each read port forwards ALUresult
//                           combinationally if the selected register is being
//                           written this cycle (reset high). When undefined,
//                           reads show stored contents only, so a written value
//                           becomes visible right after the clock edge.
//
// NUM_REGS must equal 2**SEL_W so every select value maps to a register.
// -----------------------------------------------------------------------------
module register_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic            clk,
  input  logic            reset,
  register_bank_if.slave  bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_op0;
  logic [DATA_W-1:0] w_op1;

  // Storage: reset forces every register to zero immediately and keeps it
  // there while low; otherwise every enabled register loads the same write
  // data on the edge, so en all-ones broadcasts and en zero changes nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.en[i]) begin
          r_regs[i] <= bus.ALUresult;
        end
      end
    end
  end

`ifdef REGBANK_READ_BYPASS_EN
  // Write-through: a register that is being written this cycle is read as the
  // incoming data. Gated by reset so the ports read zero while reset is low.
  always_comb begin
    w_op0 = r_regs[bus.sel0];
    if (reset && bus.en[bus.sel0]) begin
      w_op0 = bus.ALUresult;
    end
  end

  always_comb begin
    w_op1 = r_regs[bus.sel1];
    if (reset && bus.en[bus.sel1]) begin
      w_op1 = bus.ALUresult;
    end
  end
`else
  // Plain reads of stored contents: one-edge write-to-read latency.
  assign w_op0 = r_regs[bus.sel0];
  assign w_op1 = r_regs[bus.sel1];
`endif

  assign bus.Operand0 = w_op0;
  assign bus.Operand1 = w_op1;

endmodule : register_bank

// File: tb/tb_register_bank.sv
// -----------------------------------------------------------------------------
// tb_register_bank
// Self-checking bench for register_bank: directed scenarios followed by
// randomized writes, selects and reset pulses, compared against an array
// model of the register file.
// -----------------------------------------------------------------------------
module tb_register_bank;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;

  logic clk;
  logic reset;

  register_bank_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) bus ();

  register_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model [NUM_REGS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an array written on rising edges while reset is high,
  // cleared the moment reset falls.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.en[i]) model[i] = bus.ALUresult;
      end
    end
  end

  always @(negedge reset) begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  end

  // Expected read value for a select, including write-through when enabled.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [SEL_W-1:0] s);
`ifdef REGBANK_READ_BYPASS_EN
    if (reset && bus.en[s]) return bus.ALUresult;
`endif
    return model[s];
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, "_op0"}, bus.Operand0, exp_rd(bus.sel0));
    chk({tag, "_op1"}, bus.Operand1, exp_rd(bus.sel1));
  endtask

  // All 64 select pairs, each changed and sampled between clock edges.
  task automatic sweep(input string tag);
    for (int a = 0; a < NUM_REGS; a++) begin
      for (int b = 0; b < NUM_REGS; b++) begin
        @(negedge clk);
        bus.sel0 = 3'(a);
        bus.sel1 = 3'(b);
        #1;
        chk_ports(tag);
      end
    end
  endtask

  task automatic write(input logic [NUM_REGS-1:0] e, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.en        = e;
    bus.ALUresult = d;
    tick();
    bus.en = '0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.en        = '0;
    bus.ALUresult = '0;
    bus.sel0      = '0;
    bus.sel1      = '0;

    // Power-on reset asserted between edges.
    #2 reset = 1'b0;
    #1;
    chk("por_op0", bus.Operand0, 16'h0000);
    chk("por_op1", bus.Operand1, 16'h0000);
    repeat (2) tick();
    @(negedge clk);
    bus.en        = 8'hFF;
    bus.ALUresult = 16'hFFFF;
    #1;
    chk("rst_nobypass_op0", bus.Operand0, 16'h0000);
    tick();
    chk("rst_nowrite_op0", bus.Operand0, 16'h0000);
    bus.en = '0;
    @(negedge clk);
    reset = 1'b1;

    // Broadcast write: old value before the edge, new value after it.
    @(negedge clk);
    bus.en        = 8'hFF;
    bus.ALUresult = 16'h0001;
    bus.sel0      = 3'd0;
    bus.sel1      = 3'd5;
    #1;
    chk_ports("bcast_pre");
    tick();
    chk("bcast_post_op0", bus.Operand0, 16'h0001);
    chk("bcast_post_op1", bus.Operand1, 16'h0001);
    bus.en = '0;
    sweep("bcast");

    // Write disabled across several edges, then a broadcast.
    write(8'hFF, 16'h0008);
    @(negedge clk);
    bus.en        = 8'h00;
    bus.ALUresult = 16'h00F0;
    repeat (3) tick();
    sweep("en0");
    write(8'hFF, 16'h0CF0);
    @(negedge clk);
    bus.sel0 = 3'd6;
    bus.sel1 = 3'd7;
    #1;
    chk("en_ff_r6", bus.Operand0, 16'h0CF0);
    chk("en_ff_r7", bus.Operand1, 16'h0CF0);

    // Asynchronous reset pulse mid-cycle after filling with 0x1234.
    write(8'hFF, 16'h1234);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_op0", bus.Operand0, 16'h0000);
    chk("rst_async_op1", bus.Operand1, 16'h0000);
    sweep("rst");
    @(negedge clk);
    reset = 1'b1;

    // Selective one-hot write into R2 after clearing.
    @(negedge clk);
    bus.en        = 8'b0000_0100;
    bus.ALUresult = 16'hABCD;
    bus.sel0      = 3'd2;
    bus.sel1      = 3'd3;
    #1;
    chk_ports("sel_pre");
    tick();
    chk("sel_r2", bus.Operand0, 16'hABCD);
    chk("sel_r3", bus.Operand1, 16'h0000);
    bus.en = '0;
    sweep("sel");

    // Distinct values Ri = i*0x1111, then full read-port sweep.
    for (int i = 0; i < NUM_REGS; i++) begin
      write(8'(1 << i), 16'(i * 16'h1111));
    end
    sweep("distinct");

    // Read during write into R3: bypass-dependent before the edge.
    @(negedge clk);
    bus.en        = 8'b0000_1000;
    bus.ALUresult = 16'h5A5A;
    bus.sel0      = 3'd3;
    bus.sel1      = 3'd2;
    #1;
`ifdef REGBANK_READ_BYPASS_EN
    chk("bypass_r3", bus.Operand0, 16'h5A5A);
`else
    chk("nobypass_r3", bus.Operand0, 16'h3333);
`endif
    chk("bypass_r2", bus.Operand1, 16'h2222);
    tick();
    bus.en = '0;
    #1;
    chk("rdw_post_r3", bus.Operand0, 16'h5A5A);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 5))
        0:       bus.en = 8'h00;
        1:       bus.en = 8'hFF;
        2:       bus.en = 8'(1 << $urandom_range(0, 7));
        default: bus.en = 8'($urandom);
      endcase
      bus.ALUresult = 16'($urandom);
      bus.sel0      = 3'($urandom_range(0, 7));
      bus.sel1      = 3'($urandom_range(0, 7));
      #1;
      chk_ports("rnd_pre");
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        #1;
        chk("rnd_rst_op0", bus.Operand0, 16'h0000);
        chk("rnd_rst_op1", bus.Operand1, 16'h0000);
        #1 reset = 1'b1;
      end
      tick();
      chk_ports("rnd_post");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule : tb_register_bank
